// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch handshake between instr_sequencer (master) and imem (slave).
interface instr_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/commit controller: owns the PC, fetches over req/ack, gates writes with commit.
// Optional retire counter enabled by defining SEQ_RETIRE_CNT_EN.
module instr_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_sequencer_if.master         imem,
  output logic [31:0]               instruction,
  output logic                      instr_valid,
  output logic                      commit,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic                      branch_reg,
  input  logic [31:0]               branch_target,
  input  logic                      halt,
  output logic                      halted,
  output logic [31:0]               pc,
  output logic [31:0]               retire_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q;
  logic        halted_q;

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        commit = ~stall;
        if (!stall) begin
          if (halt) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_FETCH;
            if (branch_taken)
              pc_d = branch_reg ? {branch_target[31:2], 2'b00} : branch_target;
            else
              pc_d = pc_q + 32'd4;
          end
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= (state_d == S_EXEC);
      halted_q <= (state_d == S_HALTED);
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retire_q <= '0;
    else if (commit)
      retire_q <= retire_q + 32'd1;
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer against a transaction-level PC model.
module tb_instr_sequencer;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        branch_reg = 1'b0;
  logic [31:0] branch_target = '0;
  logic        halt = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        commit;
  logic        halted;
  logic [31:0] pc;
  logic [31:0] retire_count;

  instr_sequencer_if m_if ();

  instr_sequencer #(.RESET_PC(TB_RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (m_if.master),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .commit        (commit),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_reg    (branch_reg),
    .branch_target (branch_target),
    .halt          (halt),
    .halted        (halted),
    .pc            (pc),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Reference model state: architectural PC, last fetched word, retired count.
  logic [31:0] exp_pc;
  logic [31:0] exp_word;
  logic [31:0] exp_rc;
  logic        exp_halted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rc_exp();
`ifdef SEQ_RETIRE_CNT_EN
    return exp_rc;
`else
    return 32'h0;
`endif
  endfunction

  task automatic noise();
    stall         = 1'($urandom);
    halt          = 1'($urandom);
    branch_taken  = 1'($urandom);
    branch_reg    = 1'($urandom);
    branch_target = $urandom;
  endtask

  task automatic quiet();
    stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; branch_reg = 1'b0;
    m_if.imem_ack = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    quiet();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pc = TB_RESET_PC; exp_rc = '0; exp_halted = 1'b0;
    #1;
    chk("rst_req",    32'(m_if.imem_req), 32'd0);
    chk("rst_pc",     pc, TB_RESET_PC);
    chk("rst_instr",  instruction, 32'd0);
    chk("rst_valid",  32'(instr_valid), 32'd0);
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retire", retire_count, 32'd0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 6 && !m_if.imem_req; i++) begin
      noise();
      m_if.imem_ack = 1'($urandom);
      @(negedge clk);
    end
    chk("req_seen", 32'(m_if.imem_req), 32'd1);
  endtask

  task automatic fetch_phase(input int waits);
    logic [31:0] w;
    wait_req();
    chk("fetch_addr", m_if.imem_addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      noise();
      m_if.imem_ack   = 1'b0;
      m_if.imem_rdata = $urandom;
      #1;
      chk("wait_req",  32'(m_if.imem_req), 32'd1);
      chk("wait_addr", m_if.imem_addr, exp_pc);
      chk("wait_commit", 32'(commit), 32'd0);
      @(negedge clk);
    end
    w = $urandom;
    noise();
    m_if.imem_ack   = 1'b1;
    m_if.imem_rdata = w;
    exp_word = w;
    #1;
    chk("ack_req", 32'(m_if.imem_req), 32'd1);
    @(negedge clk);
    m_if.imem_ack   = 1'b0;
    m_if.imem_rdata = $urandom;
  endtask

  // kind: 0 sequential, 1 direct branch, 2 register branch, 3 halt, 4 halt with branch
  task automatic exec_phase(input int stalls, input int kind, input logic [31:0] tgt);
    logic [31:0] t;
    chk("exec_valid", 32'(instr_valid), 32'd1);
    chk("exec_instr", instruction, exp_word);
    chk("exec_req",   32'(m_if.imem_req), 32'd0);
    for (int i = 0; i < stalls; i++) begin
      noise();
      stall = 1'b1;
      m_if.imem_ack = 1'($urandom);
      #1;
      chk("stall_commit", 32'(commit), 32'd0);
      chk("stall_valid",  32'(instr_valid), 32'd1);
      chk("stall_pc",     pc, exp_pc);
      @(negedge clk);
    end
    chk("post_stall_instr", instruction, exp_word);
    stall         = 1'b0;
    m_if.imem_ack = 1'($urandom);
    branch_target = tgt;
    branch_reg    = (kind == 2) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom);
    branch_taken  = (kind == 1 || kind == 2 || kind == 4);
    halt          = (kind >= 3);
    #1;
    chk("commit", 32'(commit), 32'd1);
    if (kind >= 3) begin
      exp_halted = 1'b1;
    end else if (kind == 0) begin
      exp_pc = exp_pc + 32'd4;
    end else begin
      t = tgt;
      if (branch_reg) t = t & 32'hFFFF_FFFC;
      exp_pc = t;
    end
    exp_rc = exp_rc + 32'd1;
    @(negedge clk);
    quiet();
    #1;
    chk("next_pc",     pc, exp_pc);
    chk("next_commit", 32'(commit), 32'd0);
    chk("next_valid",  32'(instr_valid), 32'd0);
    chk("next_halted", 32'(halted), 32'(exp_halted));
    chk("retire",      retire_count, rc_exp());
  endtask

  task automatic check_halted_hold();
    for (int i = 0; i < 5; i++) begin
      noise();
      m_if.imem_ack = 1'($urandom);
      @(negedge clk);
      #1;
      chk("hold_halted", 32'(halted), 32'd1);
      chk("hold_req",    32'(m_if.imem_req), 32'd0);
      chk("hold_commit", 32'(commit), 32'd0);
      chk("hold_valid",  32'(instr_valid), 32'd0);
      chk("hold_pc",     pc, exp_pc);
    end
    quiet();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_if.imem_ack   = 1'b0;
    m_if.imem_rdata = '0;
    @(negedge clk);
    apply_reset();

    // Three back-to-back sequential words with zero memory wait.
    for (int i = 0; i < 3; i++) begin
      fetch_phase(0);
      exec_phase(0, 0, 32'h0);
    end
    chk("seq_pc", pc, 32'h0000_000C);

    fetch_phase(3);
    exec_phase(2, 0, 32'h0);
    fetch_phase(0);
    exec_phase(0, 1, 32'h0000_0040);
    fetch_phase(0);
    exec_phase(0, 2, 32'h0000_0043);
    chk("breg_pc", pc, 32'h0000_0040);

    // Wrap at the top of the address space.
    fetch_phase(1);
    exec_phase(0, 1, 32'hFFFF_FFFC);
    fetch_phase(0);
    exec_phase(1, 0, 32'h0);
    chk("wrap_pc", pc, 32'h0000_0000);

    for (int n = 0; n < 40; n++) begin
      fetch_phase(int'($urandom_range(0, 3)));
      exec_phase(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
    end

    fetch_phase(1);
    exec_phase(1, 4, 32'h0000_1234);
    check_halted_hold();

    apply_reset();
    fetch_phase(0);
    exec_phase(0, 0, 32'h0);
    fetch_phase(0);
    exec_phase(0, 3, 32'h0);
    check_halted_hold();

    // Reset while a fetch is outstanding.
    apply_reset();
    wait_req();
    m_if.imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_fetch_req", 32'(m_if.imem_req), 32'd0);
    @(negedge clk);
    m_if.imem_ack = 1'b1;
    @(negedge clk);
    chk("rst_fetch_hold", 32'(m_if.imem_req), 32'd0);
    apply_reset();
    fetch_phase(0);

    // Reset during the commit cycle.
    stall = 1'b0;
    #1;
    chk("pre_rst_commit", 32'(commit), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_exec_commit", 32'(commit), 32'd0);
    chk("rst_exec_valid",  32'(instr_valid), 32'd0);
    apply_reset();
    fetch_phase(2);
    exec_phase(0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/commit controller for the single-cycle core. It owns the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake. It presents each word to ID for exactly one commit cycle and gates the Reg_File and CPSR writes with a commit strobe. It redirects the PC on branches and stops the core on HALT.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory accepted the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instruction  out  32  latched word driven to ID.
- instr_valid  out  1  instruction is valid; high only in EXEC.
- commit  out  1  write qualifier; the top level ANDs it into Reg_File write_enable and CPSR wr_cpsr.
- stall  in  1  hold the current instruction; no commit.
- branch_taken  in  1  the current instruction redirects the PC (from ID/EXE).
- branch_reg  in  1  the target comes from a register (BR form); when 1, bits [1:0] are forced to 0.
- branch_target  in  32  redirect address.
- halt  in  1  the current instruction is HALT.
- halted  out  1  core stopped.
- pc  out  32  current program counter.
- retire_count  out  32  committed-instruction count (see Configuration).

## Operation

States: IDLE, FETCH, EXEC, HALTED.

- **Reset (async):** state=IDLE, pc=RESET_PC, instruction=0, imem_req=0, instr_valid=0, commit=0, halted=0, retire_count=0.
- **IDLE:** no outputs asserted. Next state is FETCH. This gives one cycle after reset release.
- **FETCH:**
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: instruction<=imem_rdata, next state EXEC.
  - Otherwise remain in FETCH with the request held and the address stable.
- **EXEC:**
  - instr_valid=1.
  - commit = ~stall. commit is combinational from stall within EXEC; it is 0 in every other state.
  - With stall=1: remain in EXEC; pc and instruction unchanged.
  - With stall=0 (commit=1):
    - If halt=1: next state HALTED; pc unchanged.
    - Else if branch_taken=1: pc <= branch_reg ? {branch_target[31:2],2'b00} : branch_target. Next state FETCH.
    - Else pc <= pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0). Next state FETCH.
  - halt takes priority over branch_taken.
- **HALTED:** halted=1. imem_req, instr_valid and commit are 0. The block leaves HALTED only via rst.
- imem_ack is ignored outside FETCH.
- branch_taken, halt and branch_target are ignored outside EXEC or while stall=1.

## Timing

- Minimum 2 cycles per instruction: FETCH with imem_ack in the same cycle, then EXEC.
- Each memory wait cycle adds 1 cycle. Each stall cycle adds 1 cycle.
- The pc output updates on the clock edge that ends the commit cycle.
- imem_addr in the following FETCH equals the new pc.
- All outputs except commit, imem_addr and imem_req are registered. imem_req and imem_addr are decoded from state and pc.
- **Reset asserted mid-FETCH:** imem_req drops within the same cycle (asynchronous), and any acknowledge in flight is discarded.
- **Reset asserted mid-EXEC:** commit drops immediately, and no partial write is possible.

## Configuration

- Macro `SEQ_RETIRE_CNT_EN`.
- **Defined:** retire_count increments by 1 on every clock edge where commit=1, including the committing HALT. It wraps from 32'hFFFF_FFFF to 0 and is cleared by rst.
- **Undefined:** no counter register is built; retire_count is tied to 32'h0. All other behaviour is identical.

## Test plan

- **Reset and sequential fetch:** rst pulse, imem_ack tied 1, three non-branch words.
  - Expect imem_addr sequence 0, 4, 8.
  - Expect commit high for exactly one cycle per word, 2 cycles apart.
  - With `SEQ_RETIRE_CNT_EN` defined, retire_count = 3.
- **Memory wait:** imem_ack held 0 for 3 cycles at address 4.
  - imem_req and imem_addr=4 stay stable for 4 cycles.
  - instruction latches the rdata of the acknowledge cycle.
- **Stall:** stall=1 for 2 cycles in EXEC.
  - commit=0, instr_valid=1, pc unchanged during the stall.
  - A single commit follows when stall drops, then pc+4.
- **Branch:**
  - branch_taken=1, branch_reg=0, target 32'h40: next imem_addr=32'h40.
  - branch_reg=1, target 32'h43: next imem_addr=32'h40.
  - halt=1 together with branch_taken=1: the block enters HALTED and pc is unchanged.
- **Halt and wrap:**
  - RESET_PC=32'hFFFF_FFFC, non-branch word: next imem_addr=0.
  - Then a HALT word: halted=1, imem_req=0 indefinitely; rst returns the block to IDLE.
- **Reset mid-fetch:** rst asserted while imem_req=1 and imem_ack=0.
  - imem_req=0 immediately.
  - After release, the fetch restarts at RESET_PC.
